// File: rtl/scc_mem_pkg.sv
// Shared types and address checks for the SCC memory responder.
// Optional bounds check is selected by SCC_MEM_BOUNDS_CHECK_EN in scc_mem_responder.
package scc_mem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      PEND_F = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_DATA  = 2'd1,
      OWN_FETCH = 2'd2
   } owner_e;

   localparam int WORD_BYTES = 4;

   // An address is rejected when misaligned, or (with bounds_en) when it
   // carries bits above the word-index field.
   function automatic logic addr_reject(input logic [31:0] addr,
                                        input int          aw,
                                        input logic        bounds_en);
      logic bad;
      bad = (addr[1:0] != 2'b00);
      if (bounds_en && ((addr >> (aw + 2)) != 32'd0)) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/scc_sram_1p.sv
// Single-ported word array with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module scc_sram_1p
   import scc_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
               if (be[i]) begin
                  mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/scc_mem_responder.sv
// Arbitrates SCC fetch and data requests onto one single-ported array.
// Define SCC_MEM_BOUNDS_CHECK_EN to reject addresses beyond DEPTH words.
module scc_mem_responder
   import scc_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_mem_en,
   input  logic [31:0] in_mem_addr,
   output logic        in_mem_ready,
   output logic [31:0] in_mem,
   output logic        in_mem_valid,
   input  logic        data_rd_en,
   input  logic        data_wr_en,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_out,
   output logic        data_ready,
   output logic [31:0] data_in,
   output logic        data_valid,
   output logic        data_err,
   output logic        ovf_err,
   output logic        dbg_pend_f
);

`ifdef SCC_MEM_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   state_e      state_q, state_d;
   logic        init_q, init_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic        fresp_q, fresp_d;
   logic        fzero_q, fzero_d;
   logic        dresp_q, dresp_d;
   logic        derr_q, derr_d;
   logic        dzero_q, dzero_d;
   logic        ovf_q, ovf_d;
   logic [31:0] in_mem_hold_q, in_mem_hold_d;
   logic [31:0] data_in_hold_q, data_in_hold_d;

   owner_e      owner;
   logic        ready, data_req, f_acc, d_acc;
   logic [31:0] fetch_addr;
   logic        fetch_bad, data_bad;
   logic        sram_en, sram_we;
   logic [3:0]  sram_be;
   logic [AW-1:0] sram_addr;
   logic [31:0] sram_rdata;

   // init_q keeps ready low for the first cycle after reset releases.
   assign ready    = init_q & (state_q == IDLE);
   assign data_req = data_rd_en | data_wr_en;
   assign f_acc    = in_mem_en & ready;
   assign d_acc    = data_req & ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (d_acc && f_acc) state_d = PEND_F;
         PEND_F:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      owner      = OWN_NONE;
      fetch_addr = in_mem_addr;
      if (state_q == PEND_F) begin
         owner      = OWN_FETCH;
         fetch_addr = pend_addr_q;
      end else if (d_acc) begin
         owner = OWN_DATA;
      end else if (f_acc) begin
         owner = OWN_FETCH;
      end
   end

   assign fetch_bad = addr_reject(fetch_addr, AW, BOUNDS_EN);
   assign data_bad  = addr_reject(data_addr, AW, BOUNDS_EN);

   // Rejected accesses never touch the array; their response is forced to 0.
   always_comb begin
      sram_en   = 1'b0;
      sram_we   = 1'b0;
      sram_be   = data_be;
      sram_addr = data_addr[AW+1:2];
      case (owner)
         OWN_DATA: begin
            sram_en = ~data_bad;
            sram_we = data_wr_en;
         end
         OWN_FETCH: begin
            sram_en   = ~fetch_bad;
            sram_addr = fetch_addr[AW+1:2];
         end
         default: ;
      endcase
   end

   always_comb begin
      init_d      = 1'b1;
      pend_addr_d = pend_addr_q;
      if (state_q == IDLE && d_acc && f_acc) begin
         pend_addr_d = in_mem_addr;
      end
      fresp_d = (owner == OWN_FETCH);
      fzero_d = fetch_bad;
      dresp_d = (owner == OWN_DATA);
      derr_d  = data_bad;
      dzero_d = data_bad | data_wr_en;
      ovf_d   = ovf_q | (in_mem_en & ~ready) | (data_req & ~ready);
   end

   always_comb begin
      in_mem_ready = ready;
      data_ready   = ready;
      in_mem_valid = fresp_q;
      data_valid   = dresp_q;
      data_err     = dresp_q & derr_q;
      ovf_err      = ovf_q;
      dbg_pend_f   = (state_q == PEND_F);
      in_mem       = in_mem_hold_q;
      data_in      = data_in_hold_q;
      if (fresp_q) in_mem  = fzero_q ? 32'd0 : sram_rdata;
      if (dresp_q) data_in = dzero_q ? 32'd0 : sram_rdata;
      in_mem_hold_d  = in_mem;
      data_in_hold_d = data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_q         <= 1'b0;
         pend_addr_q    <= 32'd0;
         fresp_q        <= 1'b0;
         fzero_q        <= 1'b0;
         dresp_q        <= 1'b0;
         derr_q         <= 1'b0;
         dzero_q        <= 1'b0;
         ovf_q          <= 1'b0;
         in_mem_hold_q  <= 32'd0;
         data_in_hold_q <= 32'd0;
      end else begin
         init_q         <= init_d;
         pend_addr_q    <= pend_addr_d;
         fresp_q        <= fresp_d;
         fzero_q        <= fzero_d;
         dresp_q        <= dresp_d;
         derr_q         <= derr_d;
         dzero_q        <= dzero_d;
         ovf_q          <= ovf_d;
         in_mem_hold_q  <= in_mem_hold_d;
         data_in_hold_q <= data_in_hold_d;
      end
   end

   scc_sram_1p #(.DEPTH(DEPTH), .AW(AW)) u_sram (
      .clk   (clk),
      .en    (sram_en),
      .we    (sram_we),
      .be    (sram_be),
      .addr  (sram_addr),
      .wdata (data_out),
      .rdata (sram_rdata)
   );

endmodule

// File: tb/tb_scc_mem_responder.sv
// Directed bench for scc_mem_responder: reset, store/load, byte merge,
// fetch, collision, overrun, error and mid-operation reset scenarios.
module tb_scc_mem_responder;

   logic        clk;
   logic        reset;
   logic        in_mem_en;
   logic [31:0] in_mem_addr;
   logic        in_mem_ready;
   logic [31:0] in_mem;
   logic        in_mem_valid;
   logic        data_rd_en;
   logic        data_wr_en;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_out;
   logic        data_ready;
   logic [31:0] data_in;
   logic        data_valid;
   logic        data_err;
   logic        ovf_err;
   logic        dbg_pend_f;

   int checks = 0;
   int errors = 0;

   scc_mem_responder dut (
      .clk          (clk),
      .reset        (reset),
      .in_mem_en    (in_mem_en),
      .in_mem_addr  (in_mem_addr),
      .in_mem_ready (in_mem_ready),
      .in_mem       (in_mem),
      .in_mem_valid (in_mem_valid),
      .data_rd_en   (data_rd_en),
      .data_wr_en   (data_wr_en),
      .data_be      (data_be),
      .data_addr    (data_addr),
      .data_out     (data_out),
      .data_ready   (data_ready),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .data_err     (data_err),
      .ovf_err      (ovf_err),
      .dbg_pend_f   (dbg_pend_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      in_mem_en   = 1'b0;
      in_mem_addr = 32'd0;
      data_rd_en  = 1'b0;
      data_wr_en  = 1'b0;
      data_be     = 4'h0;
      data_addr   = 32'd0;
      data_out    = 32'd0;
   endtask

   task automatic drive_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      idle_inputs();
      data_wr_en = 1'b1;
      data_addr  = addr;
      data_out   = wd;
      data_be    = be;
   endtask

   task automatic drive_load(input logic [31:0] addr);
      idle_inputs();
      data_rd_en = 1'b1;
      data_addr  = addr;
   endtask

   task automatic drive_fetch(input logic [31:0] addr);
      idle_inputs();
      in_mem_en   = 1'b1;
      in_mem_addr = addr;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      idle_inputs();
      step(); step();
      checks++; if (in_mem_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_mem_ready); end
      checks++; if (data_valid !== 1'b0 || in_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_valids: got %b%b expected 00", data_valid, in_mem_valid); end
      checks++; if (in_mem !== 32'd0 || data_in !== 32'd0) begin errors++; $display("FAIL rst_data: got %h/%h expected 0/0", in_mem, data_in); end
      reset = 1'b1;
      #1;
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b expected 0", data_ready); end
      step();
      checks++; if (in_mem_ready !== 1'b1 || data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_up: got %b%b expected 11", in_mem_ready, data_ready); end
      checks++; if (ovf_err !== 1'b0 || data_err !== 1'b0) begin errors++; $display("FAIL rst_errs: got %b%b expected 00", ovf_err, data_err); end
   endtask

   task automatic test_store_load;
      drive_store(32'h10, 32'hDEADBEEF, 4'hF);
      step();
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL sl_store_valid: got %b expected 1", data_valid); end
      checks++; if (data_in !== 32'd0 || data_err !== 1'b0) begin errors++; $display("FAIL sl_store_resp: got %h err %b expected 0 err 0", data_in, data_err); end
      drive_load(32'h10);
      step();
      checks++; if (data_valid !== 1'b1 || data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_load: got %b %h expected 1 deadbeef", data_valid, data_in); end
      idle_inputs();
      step();
      checks++; if (data_valid !== 1'b0 || data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_hold: got %b %h expected 0 deadbeef", data_valid, data_in); end
   endtask

   task automatic test_byte_merge;
      drive_store(32'h20, 32'h11223344, 4'hF);
      step();
      drive_store(32'h20, 32'h000000AA, 4'h1);
      step();
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bm_store_valid: got %b expected 1", data_valid); end
      drive_load(32'h20);
      step();
      checks++; if (data_in !== 32'h112233AA) begin errors++; $display("FAIL bm_merge: got %h expected 112233aa", data_in); end
      idle_inputs();
      step();
   endtask

   task automatic test_fetch;
      drive_store(32'h0, 32'hA0A0A0A0, 4'hF); step();
      drive_store(32'h4, 32'h0BADF00D, 4'hF); step();
      drive_store(32'h8, 32'h12345678, 4'hF); step();
      drive_fetch(32'h8);
      step();
      checks++; if (in_mem_valid !== 1'b1 || in_mem !== 32'h12345678) begin errors++; $display("FAIL f_alone: got %b %h expected 1 12345678", in_mem_valid, in_mem); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL f_no_dvalid: got %b expected 0", data_valid); end
      idle_inputs();
      step();
      checks++; if (in_mem_valid !== 1'b0 || in_mem !== 32'h12345678) begin errors++; $display("FAIL f_hold: got %b %h expected 0 12345678", in_mem_valid, in_mem); end
   endtask

   task automatic test_back_to_back;
      drive_fetch(32'h0);
      step();
      checks++; if (in_mem_valid !== 1'b1 || in_mem !== 32'hA0A0A0A0 || in_mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_fetch: got %b %h rdy %b expected 1 a0a0a0a0 rdy 1", in_mem_valid, in_mem, in_mem_ready); end
      drive_load(32'h4);
      step();
      checks++; if (data_valid !== 1'b1 || data_in !== 32'h0BADF00D || in_mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_load: got %b %h fv %b expected 1 0badf00d fv 0", data_valid, data_in, in_mem_valid); end
      idle_inputs();
      step();
   endtask

   task automatic test_collision;
      drive_load(32'h4);
      in_mem_en   = 1'b1;
      in_mem_addr = 32'h0;
      step();
      checks++; if (data_valid !== 1'b1 || data_in !== 32'h0BADF00D) begin errors++; $display("FAIL col_data: got %b %h expected 1 0badf00d", data_valid, data_in); end
      checks++; if (in_mem_valid !== 1'b0) begin errors++; $display("FAIL col_fetch_early: got %b expected 0", in_mem_valid); end
      checks++; if (in_mem_ready !== 1'b0 || data_ready !== 1'b0 || dbg_pend_f !== 1'b1) begin errors++; $display("FAIL col_ready: got %b%b pend %b expected 00 pend 1", in_mem_ready, data_ready, dbg_pend_f); end
      idle_inputs();
      step();
      checks++; if (in_mem_valid !== 1'b1 || in_mem !== 32'hA0A0A0A0) begin errors++; $display("FAIL col_fetch: got %b %h expected 1 a0a0a0a0", in_mem_valid, in_mem); end
      checks++; if (data_valid !== 1'b0 || in_mem_ready !== 1'b1) begin errors++; $display("FAIL col_after: got dv %b rdy %b expected dv 0 rdy 1", data_valid, in_mem_ready); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL col_no_ovf: got %b expected 0", ovf_err); end
   endtask

   task automatic test_overrun;
      drive_load(32'h4);
      in_mem_en   = 1'b1;
      in_mem_addr = 32'h0;
      step();
      drive_fetch(32'h8);
      step();
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", ovf_err); end
      checks++; if (in_mem_valid !== 1'b1 || in_mem !== 32'hA0A0A0A0) begin errors++; $display("FAIL ovr_buffered: got %b %h expected 1 a0a0a0a0", in_mem_valid, in_mem); end
      idle_inputs();
      step();
      checks++; if (in_mem_valid !== 1'b0) begin errors++; $display("FAIL ovr_dropped: got %b expected 0", in_mem_valid); end
      step();
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", ovf_err); end
   endtask

   task automatic test_errors;
      logic [31:0] exp_w0;
      logic        exp_oob_err;
`ifdef SCC_MEM_BOUNDS_CHECK_EN
      exp_w0      = 32'hA0A0A0A0;
      exp_oob_err = 1'b1;
`else
      exp_w0      = 32'h55667788;
      exp_oob_err = 1'b0;
`endif
      drive_load(32'h6);
      step();
      checks++; if (data_valid !== 1'b1 || data_err !== 1'b1 || data_in !== 32'd0) begin errors++; $display("FAIL err_mis_load: got %b %b %h expected 1 1 0", data_valid, data_err, data_in); end
      drive_store(32'hA, 32'hFFFFFFFF, 4'hF);
      step();
      checks++; if (data_err !== 1'b1) begin errors++; $display("FAIL err_mis_store: got %b expected 1", data_err); end
      drive_load(32'h8);
      step();
      checks++; if (data_in !== 32'h12345678 || data_err !== 1'b0) begin errors++; $display("FAIL err_no_write: got %h err %b expected 12345678 err 0", data_in, data_err); end
      drive_fetch(32'h2);
      step();
      checks++; if (in_mem_valid !== 1'b1 || in_mem !== 32'd0) begin errors++; $display("FAIL err_mis_fetch: got %b %h expected 1 0", in_mem_valid, in_mem); end
      drive_store(32'h1000, 32'h55667788, 4'hF);
      step();
      checks++; if (data_valid !== 1'b1 || data_err !== exp_oob_err) begin errors++; $display("FAIL err_oob_store: got %b err %b expected 1 err %b", data_valid, data_err, exp_oob_err); end
      drive_load(32'h0);
      step();
      checks++; if (data_in !== exp_w0) begin errors++; $display("FAIL err_oob_word0: got %h expected %h", data_in, exp_w0); end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid;
      drive_load(32'h4);
      in_mem_en   = 1'b1;
      in_mem_addr = 32'h8;
      step();
      idle_inputs();
      reset = 1'b0;
      #1;
      checks++; if (in_mem_valid !== 1'b0 || data_valid !== 1'b0 || in_mem_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_outs: got %b%b%b expected 000", in_mem_valid, data_valid, in_mem_ready); end
      checks++; if (ovf_err !== 1'b0 || in_mem !== 32'd0) begin errors++; $display("FAIL mid_rst_clear: got %b %h expected 0 0", ovf_err, in_mem); end
      step();
      reset = 1'b1;
      step();
      checks++; if (in_mem_valid !== 1'b0 || in_mem_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_nopend: got v %b rdy %b expected v 0 rdy 1", in_mem_valid, in_mem_ready); end
      step();
      checks++; if (in_mem_valid !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_quiet: got %b%b expected 00", in_mem_valid, data_valid); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_merge();
      test_fetch();
      test_back_to_back();
      test_collision();
      test_overrun();
      test_errors();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
